// File: rtl/dmem_arb_rv32.sv
// Two-requester arbiter/sequencer for the single-ported RV32 data cache.
// Requester 0 has priority; a burst cap lets a waiting requester 1 through.
module dmem_arb_rv32 #(
  parameter int unsigned MAXBURST = 4,
  parameter int unsigned MEMSIZE  = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReq0,
  input  logic        iRW0,
  input  logic [31:0] iAddr0,
  input  logic [31:0] iWData0,
  output logic        oGnt0,
  output logic        oStall0,
  output logic        oRValid0,
  output logic [31:0] oRData0,
  input  logic        iReq1,
  input  logic        iRW1,
  input  logic [31:0] iAddr1,
  input  logic [31:0] iWData1,
  output logic        oGnt1,
  output logic        oStall1,
  output logic        oRValid1,
  output logic [31:0] oRData1,
  output logic        oMEM,
  output logic        oRW,
  output logic [31:0] oMEMADDR,
  output logic [31:0] oWDATA,
  input  logic [31:0] iRDATA
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

  localparam logic [3:0] BURST_CAP = 4'(MAXBURST);

  if (MAXBURST == 0 || MAXBURST > 15) begin : g_bad_maxburst
    $error("dmem_arb_rv32: MAXBURST must be in 1..15");
  end
  if (MEMSIZE == 0) begin : g_bad_memsize
    $error("dmem_arb_rv32: MEMSIZE must be non-zero");
  end

  owner_t      owner;
  logic [3:0]  burst;
  logic        burst_full;
  logic        gnt0;
  logic        gnt1;
  logic        granted;
  logic        win_rw;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;

  logic        tag1_valid;
  logic        tag1_id;
  logic        tag2_valid;
  logic        tag2_id;

  // Requester 1 only overrides priority once requester 0 has used up its burst.
  always_comb begin
    burst_full = (owner == OWN0) && (burst == BURST_CAP);
    gnt0       = iRST & iReq0 & ~(iReq1 & burst_full);
    gnt1       = iRST & iReq1 & (~iReq0 | burst_full);
    granted    = gnt0 | gnt1;
    win_rw     = gnt1 ? iRW1    : iRW0;
    win_addr   = gnt1 ? iAddr1  : iAddr0;
    win_wdata  = gnt1 ? iWData1 : iWData0;
  end

  assign oGnt0   = gnt0;
  assign oGnt1   = gnt1;
  assign oStall0 = iRST & iReq0 & ~gnt0;
  assign oStall1 = iRST & iReq1 & ~gnt1;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      owner    <= IDLE;
      burst    <= '0;
      oMEM     <= 1'b0;
      oRW      <= 1'b1;
      oMEMADDR <= '0;
      oWDATA   <= '0;
    end else begin
      if (gnt0) begin
        owner <= OWN0;
        if (owner != OWN0) begin
          burst <= 4'd1;
        end else if (burst != BURST_CAP) begin
          burst <= burst + 4'd1;
        end
      end else if (gnt1) begin
        owner <= OWN1;
        burst <= '0;
      end else begin
        owner <= IDLE;
        burst <= '0;
      end

      // Command fields hold their last value on idle cycles; only oMEM drops.
      oMEM <= granted;
      if (granted) begin
        oRW      <= win_rw;
        oMEMADDR <= win_addr;
        oWDATA   <= win_wdata;
      end
    end
  end

  // Two-stage tag pipe matches the one-cycle cache read latency after issue.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      tag1_valid <= 1'b0;
      tag1_id    <= 1'b0;
      tag2_valid <= 1'b0;
      tag2_id    <= 1'b0;
    end else begin
      tag1_valid <= granted & win_rw;
      tag1_id    <= gnt1;
      tag2_valid <= tag1_valid;
      tag2_id    <= tag1_id;
    end
  end

  assign oRValid0 = tag2_valid & ~tag2_id;
  assign oRValid1 = tag2_valid &  tag2_id;
  assign oRData0  = iRDATA;
  assign oRData1  = iRDATA;

  a_one_grant : assert property (@(posedge iCLK) disable iff (!iRST)
    !(oGnt0 && oGnt1));
  a_one_rvalid : assert property (@(posedge iCLK) disable iff (!iRST)
    !(oRValid0 && oRValid1));

endmodule

// File: doc/dmem_arb_rv32.md
# dmem_arb_rv32

Two-port arbiter and sequencer for the single-ported RV32 data cache. It shares the cache between requester 0 (the core load/store unit) and requester 1 (the program loader / debug port). Each cycle it grants at most one request and issues a registered cache command. It routes read data back to the issuing requester with a fixed latency. Requester 0 has priority; a burst limit prevents requester 1 from starving.

## Interface
- MAXBURST, 4, max consecutive grants to requester 0 while requester 1 waits (1..15)
- MEMSIZE, 8, cache depth in words; addresses are taken modulo MEMSIZE by the cache, not checked here

- iCLK  in  1  clock, all state on rising edge
- iRST  in  1  reset, asynchronous, active-low (0 = reset)
- iReq0  in  1  requester 0 request, held until granted
- iRW0  in  1  requester 0: 1 = read, 0 = write
- iAddr0  in  32  requester 0 word address
- iWData0  in  32  requester 0 write data
- oGnt0  out  1  requester 0 granted this cycle (combinational)
- oStall0  out  1  iReq0 & ~oGnt0
- oRValid0  out  1  read data for requester 0 valid this cycle
- oRData0  out  32  read data to requester 0
- iReq1, iRW1, iAddr1, iWData1, oGnt1, oStall1, oRValid1, oRData1: same as requester 0, for requester 1
- oMEM  out  1  cache command valid
- oRW  out  1  cache command: 1 = read, 0 = write
- oMEMADDR  out  32  cache address
- oWDATA  out  32  cache write data
- iRDATA  in  32  cache read data, valid one cycle after the command cycle

## Operation
- State register `owner`: IDLE, OWN0, OWN1. It records the last granted requester. Separate 4-bit counter `burst`.
- Grant decision is combinational from iReq0/iReq1, owner and burst:
  - Neither request: no grant.
  - Only one request: grant that requester.
  - Both requesting and owner = OWN0 with burst == MAXBURST: grant 1.
  - Both requesting otherwise: grant 0.
- oGnt0 and oGnt1 are never both 1.
- State transitions on each grant:
  - Grant 0: owner <= OWN0. burst <= burst+1 if owner was OWN0, else 1. burst saturates at MAXBURST.
  - Grant 1: owner <= OWN1, burst <= 0.
  - No grant: owner <= IDLE, burst <= 0.
- Issue on a granted cycle T: at the edge ending T, register oMEM=1 with oRW, oMEMADDR and oWDATA from the winner. With no grant, oMEM <= 0 and the other command outputs hold their values.
- Read return:
  - A 2-stage tag pipe {valid, id} is loaded with {grant & read, winner}.
  - Stage 2 drives oRValidN = valid & (id == N).
  - oRData0 = oRData1 = iRDATA; the data is only meaningful when the matching oRValid is set.
- Writes produce no return.
- Requests complete in grant order. A read after a write to the same address returns the new data, because the cache is in-order.
- The requester must hold iReq/iRW/iAddr/iWData stable while stalled. It may present its next request in the cycle after the grant.

## Timing
- Reset (iRST=0, asynchronous):
  - owner=IDLE, burst=0.
  - oMEM=0, oRW=1, oMEMADDR=0, oWDATA=0.
  - Tag pipe cleared, so oRValid0 = oRValid1 = 0.
  - oGnt and oStall follow their equations; both are 0 while reset is asserted. Grants are suppressed while iRST=0.
- Reset release: the first grant is possible in the first cycle with iRST=1.
- Reset during an in-flight read: the read is dropped and no oRValid appears afterwards.
- Grant latency: same cycle as the request if the requester wins.
- Command: visible on the cache port in cycle T+1.
- Read data: oRValidN and oRData valid in cycle T+2, one cycle wide.
- Throughput: one transaction per cycle, back-to-back. Reads and writes may interleave freely.
- Simultaneous events:
  - Both requests in the same cycle: resolved by the priority/burst rule; the loser's oStall=1.
  - Grant to requester 1 when burst == MAXBURST: burst is reset in the same edge.

## Test plan
- Reset: hold iRST=0 with both iReq=1 -> oGnt0=oGnt1=0, oMEM=0, oRValid=0. Release -> oGnt0=1 in the first cycle.
- Single read: req0 writes 0xDEADBEEF to addr 3 (T), then reads addr 3 (T+1) -> oMEM=1, oRW=0 at T+1; oMEM=1, oRW=1 at T+2; oRValid0=1 with oRData0=0xDEADBEEF at T+3.
- Back-to-back: req1 reads addrs 0,1,2 on consecutive cycles -> oGnt1=1 for 3 cycles, oRValid1=1 on 3 consecutive cycles with data in order.
- Contention and fairness: both requesting continuously with MAXBURST=4 -> grant pattern 0,0,0,0,1 repeating; oStall1=1 on exactly the cycles where oGnt0=1.
- Routing: interleaved reads alternating 0/1 -> oRValid0 and oRValid1 never both 1, each carrying its own address's data.
- Reset mid-read: assert iRST=0 in T+1 after a read grant -> no oRValid in T+2 or later.
